// File: rtl/ram_arb_pkg.sv
// rtl/ram_arb_pkg.sv - shared types and constants for the soc_mem CPU/DMA arbiter
package ram_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_e;

  localparam int         RAM_ADDR_W = 22;
  localparam logic [3:0] WEN_FULL   = 4'hF;

endpackage

// File: rtl/ram_arb_starve_ctr.sv
// rtl/ram_arb_starve_ctr.sv - counts DMA wins against a waiting CPU and raises the CPU slot
// Built into ram_arbiter only when RAM_ARB_FAIR_EN is defined.
module ram_arb_starve_ctr #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic cpu_valid_i,
  input  logic cpu_issue_i,
  input  logic cpu_lose_i,
  output logic force_cpu_o
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (cpu_issue_i || !cpu_valid_i) begin
      cnt_d = 8'd0;
    end else if (cpu_lose_i && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign force_cpu_o = (cnt_q == 8'(STARVE_LIMIT));

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - shares soc_mem between the picorv32 port and the DMA master
// Define RAM_ARB_FAIR_EN to add the CPU anti-starvation slot; otherwise DMA always wins.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int MEM_WORDS    = 256,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  cpu_valid,
  input  logic [31:0]           cpu_addr,
  input  logic [31:0]           cpu_wdata,
  input  logic [3:0]            cpu_wstrb,
  output logic                  cpu_ready,
  output logic [31:0]           cpu_rdata,
  input  logic                  dma_req,
  input  logic [31:0]           dma_addr,
  input  logic [31:0]           dma_wdata,
  input  logic                  dma_wen,
  input  logic                  dma_ren,
  output logic                  dma_grant,
  output logic                  dma_rvalid,
  output logic [31:0]           dma_rdata,
  output logic [3:0]            ram_wen,
  output logic [RAM_ADDR_W-1:0] ram_addr,
  output logic [31:0]           ram_wdata,
  input  logic [31:0]           ram_rdata
);

  localparam logic [31:0] ADDR_LIMIT = 32'(4 * MEM_WORDS);

  owner_e      resp_owner_q, resp_owner_d;
  logic        resp_is_rd_q, resp_is_rd_d;
  logic        resp_oob_q, resp_oob_d;
  owner_e      winner;
  logic        dma_elig, cpu_elig, force_cpu;
  logic [31:0] sel_addr;
  logic        sel_oob;
  logic        rd_data_ok;

  assign dma_elig = dma_req && (dma_wen || dma_ren);
  // The CPU still holds cpu_valid during its own response cycle; keep it out then.
  assign cpu_elig = cpu_valid && (resp_owner_q != OWN_CPU);

  always_comb begin
    winner = OWN_NONE;
    if (dma_elig && !(force_cpu && cpu_elig)) begin
      winner = OWN_DMA;
    end else if (cpu_elig) begin
      winner = OWN_CPU;
    end
  end

  assign sel_addr  = (winner == OWN_DMA) ? dma_addr : cpu_addr;
  assign sel_oob   = (sel_addr >= ADDR_LIMIT);
  assign ram_addr  = sel_addr[RAM_ADDR_W+1:2];
  assign ram_wdata = (winner == OWN_DMA) ? dma_wdata : cpu_wdata;
  assign dma_grant = (winner == OWN_DMA);

  always_comb begin
    ram_wen      = 4'b0000;
    resp_is_rd_d = 1'b0;
    resp_owner_d = winner;
    resp_oob_d   = sel_oob;
    case (winner)
      OWN_CPU: begin
        ram_wen      = cpu_wstrb;
        resp_is_rd_d = (cpu_wstrb == 4'b0000);
      end
      OWN_DMA: begin
        ram_wen      = dma_wen ? WEN_FULL : 4'b0000;
        resp_is_rd_d = !dma_wen;
      end
      default: ;
    endcase
    // Addresses beyond the array alias into it through ram_addr; never let them write.
    if (sel_oob) begin
      ram_wen = 4'b0000;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      resp_owner_q <= OWN_NONE;
      resp_is_rd_q <= 1'b0;
      resp_oob_q   <= 1'b0;
    end else begin
      resp_owner_q <= resp_owner_d;
      resp_is_rd_q <= resp_is_rd_d;
      resp_oob_q   <= resp_oob_d;
    end
  end

  assign rd_data_ok = resp_is_rd_q && !resp_oob_q;
  assign cpu_ready  = (resp_owner_q == OWN_CPU);
  assign cpu_rdata  = (cpu_ready && rd_data_ok) ? ram_rdata : 32'd0;
  assign dma_rvalid = (resp_owner_q == OWN_DMA) && resp_is_rd_q;
  assign dma_rdata  = (dma_rvalid && rd_data_ok) ? ram_rdata : 32'd0;

`ifdef RAM_ARB_FAIR_EN
  ram_arb_starve_ctr #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve_ctr (
    .clk        (clk),
    .resetn     (resetn),
    .cpu_valid_i(cpu_valid),
    .cpu_issue_i(winner == OWN_CPU),
    .cpu_lose_i (cpu_elig && (winner == OWN_DMA)),
    .force_cpu_o(force_cpu)
  );
`else
  assign force_cpu = 1'b0;
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - directed and randomized checks of ram_arbiter against a reference model
// Expectations for the contention case follow RAM_ARB_FAIR_EN.
module tb_ram_arbiter;

  localparam int MEM_WORDS    = 256;
  localparam int STARVE_LIMIT = 4;
`ifdef RAM_ARB_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic        cpu_valid;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [3:0]  cpu_wstrb;
  logic        cpu_ready;
  logic [31:0] cpu_rdata;
  logic        dma_req;
  logic [31:0] dma_addr, dma_wdata;
  logic        dma_wen, dma_ren;
  logic        dma_grant, dma_rvalid;
  logic [31:0] dma_rdata;
  logic [3:0]  ram_wen;
  logic [21:0] ram_addr;
  logic [31:0] ram_wdata, ram_rdata;

  logic [31:0] mem [0:MEM_WORDS-1];
  logic [31:0] mm  [0:MEM_WORDS-1];
  logic        pl_en;
  int          pl_idx;
  logic [31:0] pl_data;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.MEM_WORDS(MEM_WORDS), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .resetn(resetn),
    .cpu_valid(cpu_valid), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb),
    .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_wen(dma_wen),
    .dma_ren(dma_ren), .dma_grant(dma_grant), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // soc_mem stand-in: synchronous read, byte writes, garbage beyond the array
  always @(posedge clk) begin
    if (pl_en) begin
      mem[pl_idx] <= pl_data;
    end else if (int'(ram_addr) < MEM_WORDS) begin
      ram_rdata <= mem[ram_addr];
      for (int b = 0; b < 4; b++)
        if (ram_wen[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    end else begin
      ram_rdata <= 32'hBAD0_BAD0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_valid = 1'b0; cpu_addr = 32'd0; cpu_wdata = 32'd0; cpu_wstrb = 4'd0;
    dma_req = 1'b0; dma_addr = 32'd0; dma_wdata = 32'd0; dma_wen = 1'b0; dma_ren = 1'b0;
  endtask

  function automatic logic [31:0] pat(input int i);
    return 32'h9E37_79B9 * 32'(i) + 32'h0000_1234;
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    case ($urandom_range(0, 11))
      0:       a = 32'h0000_0400 + ($urandom_range(0, 255) << 2);
      1:       a = 32'h1000_0000 | ($urandom_range(0, 255) << 2);
      2:       a = 32'hFFFF_FFFC;
      default: a = {22'd0, 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3))};
    endcase
    return a;
  endfunction

  function automatic bit in_range(input logic [31:0] a);
    return a < 32'(4 * MEM_WORDS);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL timeout got=0x00000000 exp=0x00000001");
    $fatal(1, "timeout");
  end

  initial begin
    int          ready_cyc, grants;
    logic [31:0] got_data, wd;
    bit          exp_cpu, exp_dma, cpu_done, cpu_ok, dma_ok, cpu_turn, win_cpu, win_dma;
    logic [31:0] exp_cpu_d, exp_dma_d, a;
    logic [3:0]  exp_wen;
    int          streak;

    resetn = 1'b0; pl_en = 1'b0; pl_idx = 0; pl_data = 32'd0;
    idle_inputs();
    cpu_addr = 32'h0000_1234;

    // preload while held in reset; outputs must stay quiet throughout
    for (int i = 0; i < MEM_WORDS + 2; i++) begin
      @(negedge clk);
      pl_en = 1'b1;
      pl_idx = (i < MEM_WORDS) ? i : (i == MEM_WORDS ? 'h10 : 'h11);
      pl_data = (i < MEM_WORDS) ? pat(i) : (i == MEM_WORDS ? 32'hDEAD_BEEF : 32'h1122_3344);
    end
    @(negedge clk);
    pl_en = 1'b0;
    check("rst_cpu_ready", cpu_ready, 0);
    check("rst_cpu_rdata", cpu_rdata, 0);
    check("rst_dma_grant", dma_grant, 0);
    check("rst_dma_rvalid", dma_rvalid, 0);
    check("rst_dma_rdata", dma_rdata, 0);
    check("rst_ram_wen", ram_wen, 0);
    check("rst_ram_addr", ram_addr, 32'h48D);
    step(); resetn = 1'b1;

    // CPU read alone
    step(); cpu_valid = 1; cpu_addr = 32'h40; cpu_wstrb = 0;
    @(negedge clk);
    check("rd_grant", dma_grant, 0);
    check("rd_ram_addr", ram_addr, 32'h10);
    check("rd_ready_early", cpu_ready, 0);
    step(); @(negedge clk);
    check("rd_ready", cpu_ready, 1);
    check("rd_data", cpu_rdata, 32'hDEAD_BEEF);
    check("rd_resp_wen", ram_wen, 0);
    step(); idle_inputs();

    // CPU byte write
    step(); cpu_valid = 1; cpu_addr = 32'h44; cpu_wstrb = 4'b0010; cpu_wdata = 32'h0000_AB00;
    @(negedge clk);
    check("wr_ram_wen", ram_wen, 4'b0010);
    check("wr_ram_addr", ram_addr, 32'h11);
    step(); @(negedge clk);
    check("wr_ready", cpu_ready, 1);
    check("wr_rdata", cpu_rdata, 0);
    step(); idle_inputs();
    @(negedge clk);
    check("wr_mem", mem['h11], 32'h1122_AB44);

    // DMA read burst of 8 words
    for (int k = 0; k <= 8; k++) begin
      step();
      if (k < 8) begin
        dma_req = 1; dma_ren = 1; dma_wen = 0; dma_addr = 32'(4 * ('h20 + k));
      end else begin
        idle_inputs();
      end
      @(negedge clk);
      if (k < 8) check($sformatf("burst_grant%0d", k), dma_grant, 1);
      check($sformatf("burst_rvalid%0d", k), dma_rvalid, (k > 0) ? 1 : 0);
      check($sformatf("burst_rdata%0d", k), dma_rdata, (k > 0) ? pat('h20 + k - 1) : 0);
    end
    step(); @(negedge clk);
    check("burst_rvalid_end", dma_rvalid, 0);

    // contention: continuous DMA writes against a waiting CPU read
    ready_cyc = 0; grants = 0; got_data = 0;
    for (int c = 1; c <= 24 && ready_cyc == 0; c++) begin
      step();
      if (c == 1) begin
        dma_req = 1; dma_wen = 1; dma_ren = 0; dma_addr = 32'(4 * 'h30); dma_wdata = 32'h5555_0000;
        cpu_valid = 1; cpu_addr = 32'(4 * 'h31); cpu_wstrb = 0;
      end
      if (c == 21) dma_req = 0;
      @(negedge clk);
      if (cpu_ready) begin
        ready_cyc = c; got_data = cpu_rdata;
      end else if (dma_grant) begin
        grants++;
      end
    end
    check("cont_ready_cycle", ready_cyc, FAIR ? 6 : 22);
    check("cont_dma_grants", grants, FAIR ? 4 : 20);
    check("cont_rdata", got_data, pat('h31));
    step(); idle_inputs();

    // out-of-range accesses
    step(); dma_req = 1; dma_wen = 1; dma_addr = 32'h400; dma_wdata = 32'hFFFF_FFFF;
    @(negedge clk);
    check("oob_dma_grant", dma_grant, 1);
    check("oob_dma_wen", ram_wen, 0);
    step(); dma_addr = 32'h1000_0000; dma_wdata = 32'h1234_5678;
    @(negedge clk);
    check("oob_alias_wen", ram_wen, 0);
    step(); dma_wen = 0; dma_ren = 1; dma_addr = 32'h400;
    step(); idle_inputs(); @(negedge clk);
    check("oob_dma_rvalid", dma_rvalid, 1);
    check("oob_dma_rdata", dma_rdata, 0);
    step(); cpu_valid = 1; cpu_addr = 32'h400;
    step(); @(negedge clk);
    check("oob_cpu_ready", cpu_ready, 1);
    check("oob_cpu_rdata", cpu_rdata, 0);
    step(); idle_inputs();
    step(); cpu_valid = 1; cpu_addr = 32'h1000_0000;
    step(); @(negedge clk);
    check("oob_alias_ready", cpu_ready, 1);
    check("oob_alias_rdata", cpu_rdata, 0);
    check("oob_mem_intact", mem[0], pat(0));
    step(); idle_inputs();

    // reset in the response cycle of a CPU read
    step(); cpu_valid = 1; cpu_addr = 32'h48;
    step(); resetn = 0; idle_inputs();
    @(negedge clk);
    check("mrst_ready", cpu_ready, 0);
    check("mrst_rdata", cpu_rdata, 0);
    check("mrst_wen", ram_wen, 0);
    step(); @(negedge clk);
    check("mrst_ready2", cpu_ready, 0);
    step(); resetn = 1;
    step(); cpu_valid = 1; cpu_addr = 32'h48;
    step(); @(negedge clk);
    check("mrst_after_ready", cpu_ready, 1);
    check("mrst_after_rdata", cpu_rdata, pat('h12));
    step(); idle_inputs();
    step();

    // randomized traffic against the reference model
    for (int i = 0; i < MEM_WORDS; i++) mm[i] = mem[i];
    streak = 0; exp_cpu = 0; exp_dma = 0; exp_cpu_d = 0; exp_dma_d = 0; cpu_done = 0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      step();
      if (cpu_done) begin
        cpu_valid = 0; cpu_done = 0;
      end
      if (!cpu_valid && $urandom_range(0, 1) == 1) begin
        cpu_valid = 1; cpu_addr = rand_addr(); cpu_wdata = $urandom;
        cpu_wstrb = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'h0;
      end
      dma_req = ($urandom_range(0, 3) != 0); dma_addr = rand_addr(); dma_wdata = $urandom;
      dma_wen = 1'($urandom_range(0, 1)); dma_ren = 1'($urandom_range(0, 1));

      dma_ok   = dma_req && (dma_wen || dma_ren);
      cpu_ok   = cpu_valid && !exp_cpu;
      cpu_turn = FAIR && cpu_ok && (streak >= STARVE_LIMIT);
      win_dma  = dma_ok && !cpu_turn;
      win_cpu  = cpu_ok && !win_dma;
      a        = win_dma ? dma_addr : cpu_addr;
      wd       = win_dma ? dma_wdata : cpu_wdata;
      exp_wen  = 4'h0;
      if (in_range(a)) exp_wen = win_cpu ? cpu_wstrb : ((win_dma && dma_wen) ? 4'hF : 4'h0);

      @(negedge clk);
      check("rnd_cpu_ready", cpu_ready, exp_cpu);
      check("rnd_cpu_rdata", cpu_rdata, exp_cpu_d);
      check("rnd_dma_rvalid", dma_rvalid, exp_dma);
      check("rnd_dma_rdata", dma_rdata, exp_dma_d);
      check("rnd_dma_grant", dma_grant, win_dma);
      check("rnd_ram_wen", ram_wen, exp_wen);
      check("rnd_ram_addr", ram_addr, a >> 2 & 32'h3F_FFFF);
      check("rnd_ram_wdata", ram_wdata, wd);
      if (exp_cpu) cpu_done = 1;

      exp_cpu   = win_cpu;
      exp_cpu_d = (win_cpu && cpu_wstrb == 4'h0 && in_range(a)) ? mm[a[9:2]] : 32'd0;
      exp_dma   = win_dma && !dma_wen;
      exp_dma_d = (exp_dma && in_range(a)) ? mm[a[9:2]] : 32'd0;
      if (in_range(a))
        for (int b = 0; b < 4; b++)
          if (exp_wen[b]) mm[a[9:2]][8*b +: 8] = wd[8*b +: 8];
      if (win_cpu || !cpu_valid) streak = 0;
      else if (win_dma && cpu_ok) streak++;
    end
    step(); idle_inputs();
    step(); step();
    for (int i = 0; i < MEM_WORDS; i++) check($sformatf("rnd_mem%0d", i), mem[i], mm[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
